// File: rtl/ntt_pre_proc_ctrl.sv
// ntt_pre_proc_ctrl: load / wait-full / compute / drain sequencer for the NTT pre-processing unit
module ntt_pre_proc_ctrl #(
  parameter int N       = 256,
  parameter int LANES   = 8,
  parameter int CW      = 8,
  parameter int PIPE    = 4,
  parameter int FULL_TO = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          full,
  input  logic          half_full,
  input  logic          hold,
  output logic          int_o,
  output logic          out_o,
  output logic          ntt_intt_sel,
  output logic [CW-1:0] counter,
  output logic [CW:0]   load_cnt,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int GW = $clog2(N / LANES);
  localparam int TW = $clog2(FULL_TO);
  localparam int DW = $clog2(PIPE + 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_FULL, COMPUTE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic sel_q, sel_d, err_q, err_d, hf_pend_q, hf_pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0] lcnt_q, lcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [DW-1:0] drn_q, drn_d;
  logic beat, last;
  assign beat = state_q == LOAD && in_valid;
  // last schedule slot: final group of the final stage
  assign last = cnt_q[CW-1:GW] == (CW-GW)'(LANES - 1) && cnt_q[GW-1:0] == GW'(N / LANES - 1);
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    lcnt_d    = lcnt_q;
    tmo_d     = '0;
    drn_d     = '0;
    hf_pend_d = beat && lcnt_q == (CW+1)'(N / 2 - 1);
    if (hf_pend_q && !half_full) err_d = 1'b1;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        sel_d   = mode;
        err_d   = 1'b0;
        cnt_d   = '0;
        lcnt_d  = '0;
      end
      LOAD: if (in_valid) begin
        lcnt_d  = lcnt_q + 1'b1;
        state_d = lcnt_q == (CW+1)'(N - 1) ? WAIT_FULL : LOAD;
      end
      WAIT_FULL: if (full) state_d = COMPUTE;
      else if (tmo_q == TW'(FULL_TO - 2)) begin
        state_d = DONE;
        err_d   = 1'b1;
      end else tmo_d = tmo_q + 1'b1;
      COMPUTE: if (!hold) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? DRAIN : COMPUTE;
      end
      DRAIN: if (drn_q == DW'(PIPE)) state_d = DONE;
      else drn_d = drn_q + 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      err_q     <= 1'b0;
      hf_pend_q <= 1'b0;
      cnt_q     <= '0;
      lcnt_q    <= '0;
      tmo_q     <= '0;
      drn_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
      hf_pend_q <= hf_pend_d;
      cnt_q     <= cnt_d;
      lcnt_q    <= lcnt_d;
      tmo_q     <= tmo_d;
      drn_q     <= drn_d;
    end
  end
  assign in_ready     = state_q == LOAD;
  assign int_o        = beat;
  assign out_o        = state_q == COMPUTE && !hold;
  assign ntt_intt_sel = sel_q;
  assign counter      = cnt_q;
  assign load_cnt     = lcnt_q;
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE;
  assign err          = err_q;
endmodule

// File: tb/tb_ntt_pre_proc_ctrl.sv
// tb_ntt_pre_proc_ctrl: scoreboard bench for the NTT pre-processing sequencer
module tb_ntt_pre_proc_ctrl;
  localparam int N = 256, CW = 8, PIPE = 4, FULL_TO = 16;
  logic clk = 1'b0;
  logic rst, start, mode, in_valid, full, half_full, hold;
  logic in_ready, int_o, out_o, ntt_intt_sel, busy, done, err;
  logic [CW-1:0] counter;
  logic [CW:0] load_cnt;
  int checks = 0, errors = 0, cyc = 0, n_int = 0, n_out = 0, last_out = -1;
  logic [CW:0] ld_q[$];
  logic [CW-1:0] out_q[$];

  ntt_pre_proc_ctrl #(.N(N), .LANES(8), .CW(CW), .PIPE(PIPE), .FULL_TO(FULL_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .full(full), .half_full(half_full), .hold(hold), .int_o(int_o), .out_o(out_o),
    .ntt_intt_sel(ntt_intt_sel), .counter(counter), .load_cnt(load_cnt), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic run_job(input logic m, input bit tog, input bit early, input bit hf_ok, input int fdel,
                         input int hold_at, input int hold_len, input int rst_at, input bit keep);
    int beats, k, last_beat, exp_first, exp_done, guard;
    bit got;
    logic exp_err;
    exp_err = !hf_ok || fdel < 0;
    ld_q.delete(); out_q.delete();
    n_int = 0; n_out = 0; last_out = -1; exp_first = 0;
    for (int i = 0; i < N; i++) begin
      ld_q.push_back((CW+1)'(i));
      if (fdel >= 0) out_q.push_back(CW'(i));
    end
    @(posedge clk); #1 start = 1; mode = m;
    @(posedge clk); #1 start = keep; mode = !m;
    @(negedge clk); checks++;
    if ({in_ready, busy, err, ntt_intt_sel} !== {3'b110, m} || load_cnt !== '0) begin
      errors++; $display("FAIL load_entry rdy/busy/err/sel=%b load_cnt=%0d expected %b/0", {in_ready, busy, err, ntt_intt_sel}, load_cnt, {3'b110, m});
    end
    beats = 0; k = 0; last_beat = 0;
    while (beats < N && k < 3 * N) begin
      @(posedge clk); #1;
      in_valid  = !tog || k % 2 == 0;
      half_full = hf_ok && beats >= N / 2;
      full      = early && beats == 100;
      @(negedge clk); checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_load beat %0d got %b expected 1", beats, in_ready); end
      if (in_valid) begin beats++; last_beat = cyc; end
      k++;
    end
    @(posedge clk); #1 in_valid = 0; full = 0; half_full = hf_ok;
    @(negedge clk); checks++;
    if (in_ready !== 1'b0 || load_cnt !== (CW+1)'(N) || busy !== 1'b1) begin
      errors++; $display("FAIL wait_full_entry in_ready=%b load_cnt=%0d busy=%b expected 0/%0d/1", in_ready, load_cnt, busy, N);
    end
    if (fdel < 0) exp_done = last_beat + FULL_TO;
    else begin
      repeat (fdel - 1) @(posedge clk);
      #1 full = 1;
      exp_first = cyc + 1;
      exp_done = exp_first + N + PIPE + 1 + hold_len;
      if (hold_len > 0) begin
        repeat (hold_at + 1) @(posedge clk);
        #1 hold = 1;
        repeat (hold_len) begin
          @(negedge clk); checks++;
          if (counter !== CW'(hold_at) || out_o !== 1'b0) begin
            errors++; $display("FAIL hold_freeze counter=%0d out_o=%b expected %0d/0", counter, out_o, hold_at);
          end
          @(posedge clk); #1;
        end
        hold = 0;
      end
    end
    if (rst_at >= 0) begin
      repeat (rst_at + 1) @(posedge clk);
      @(negedge clk); checks++;
      if (counter !== CW'(rst_at) || out_o !== 1'b1) begin
        errors++; $display("FAIL pre_reset counter=%0d out_o=%b expected %0d/1", counter, out_o, rst_at);
      end
      rst = 1;
      @(posedge clk); #1 rst = 0; full = 0; half_full = 0;
      @(negedge clk); checks++;
      if ({out_o, busy, ntt_intt_sel, err, int_o} !== 5'b0 || counter !== '0) begin
        errors++; $display("FAIL mid_reset out/busy/sel/err/int=%b counter=%0d expected 00000/0", {out_o, busy, ntt_intt_sel, err, int_o}, counter);
      end
      out_q.delete();
    end else begin
      got = 0; guard = 0;
      while (!got && guard < 2 * N + 100) begin
        @(negedge clk);
        if (done === 1'b1) got = 1; else guard++;
      end
      checks++;
      if (!got || cyc != exp_done) begin errors++; $display("FAIL done_cycle got %0d (seen=%0d) expected %0d", cyc, got, exp_done); end
      checks++;
      if (err !== exp_err || ntt_intt_sel !== m || busy !== 1'b1) begin
        errors++; $display("FAIL done_status err=%b sel=%b busy=%b expected %b/%b/1", err, ntt_intt_sel, busy, exp_err, m);
      end
      if (fdel >= 0) begin
        checks++;
        if (last_out != exp_done - PIPE - 2) begin errors++; $display("FAIL last_strobe got %0d expected %0d", last_out, exp_done - PIPE - 2); end
      end
      @(posedge clk); #1 full = 0; half_full = 0;
      @(negedge clk); checks++;
      if ({busy, done, out_o, int_o} !== 4'b0 || counter !== '0) begin
        errors++; $display("FAIL idle_after_done busy/done/out/int=%b counter=%0d expected 0000/0", {busy, done, out_o, int_o}, counter);
      end
      checks++;
      if (n_int != N || n_out != (fdel < 0 ? 0 : N) || ld_q.size() != 0 || out_q.size() != 0) begin
        errors++; $display("FAIL strobe_counts int=%0d out=%0d left=%0d/%0d expected %0d/%0d/0/0", n_int, n_out, ld_q.size(), out_q.size(), N, fdel < 0 ? 0 : N);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; mode = 0; in_valid = 0; full = 0; half_full = 0; hold = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); checks++;
    if ({in_ready, int_o, out_o, ntt_intt_sel, busy, done, err} !== 7'b0 || counter !== '0 || load_cnt !== '0) begin
      errors++; $display("FAIL reset_outputs flags=%b counter=%0d load_cnt=%0d expected all 0", {in_ready, int_o, out_o, ntt_intt_sel, busy, done, err}, counter, load_cnt);
    end
    @(posedge clk); #1 rst = 0; in_valid = 1;
    repeat (2) begin
      @(negedge clk); checks++;
      if ({in_ready, int_o, busy} !== 3'b0 || load_cnt !== '0) begin
        errors++; $display("FAIL idle_ignores_valid rdy/int/busy=%b load_cnt=%0d expected 000/0", {in_ready, int_o, busy}, load_cnt);
      end
    end
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic test_basic();       run_job(1, 0, 0, 1, 2, 0, 0, -1, 0); endtask
  task automatic test_toggle();      run_job(1, 1, 1, 1, 2, 0, 0, -1, 0); endtask
  task automatic test_hold();
    run_job(1, 0, 0, 1, 2, 112, 5, -1, 0);
    run_job(0, 0, 0, 0, 2, 2, 5, -1, 0);
  endtask
  task automatic test_timeout();
    run_job(1, 0, 0, 1, -1, 0, 0, -1, 0);
    run_job(1, 0, 0, 1, 2, 0, 0, -1, 0);
  endtask
  task automatic test_reset_mid();
    run_job(1, 0, 0, 1, 2, 0, 0, 40, 0);
    run_job(0, 0, 0, 1, 2, 0, 0, -1, 0);
  endtask
  task automatic test_back_to_back();
    run_job(1, 0, 0, 1, 2, 0, 0, -1, 1);
    @(negedge clk); checks++;
    if ({busy, in_ready, ntt_intt_sel} !== 3'b110 || load_cnt !== '0) begin
      errors++; $display("FAIL held_start_rejob busy/rdy/sel=%b load_cnt=%0d expected 110/0", {busy, in_ready, ntt_intt_sel}, load_cnt);
    end
    start = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    fork
      begin : mon
        logic [CW:0] el;
        logic [CW-1:0] eo;
        forever begin
          @(negedge clk);
          if (int_o === 1'b1) begin
            n_int++; checks++;
            if (ld_q.size() == 0) begin errors++; $display("FAIL int_o_extra load_cnt=%0d expected no beat", load_cnt); end
            else begin
              el = ld_q.pop_front();
              if (load_cnt !== el) begin errors++; $display("FAIL int_o_load_cnt got %0d expected %0d", load_cnt, el); end
            end
          end
          if (out_o === 1'b1) begin
            n_out++; checks++; last_out = cyc;
            if (out_q.size() == 0) begin errors++; $display("FAIL out_o_extra counter=%0d expected no strobe", counter); end
            else begin
              eo = out_q.pop_front();
              if (counter !== eo) begin errors++; $display("FAIL out_o_counter got %0d expected %0d", counter, eo); end
            end
          end
        end
      end
    join_none
    test_reset();
    test_basic();
    test_toggle();
    test_hold();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
